mips_dmem_mmio: RTL and testbench
=================================

# mips_dmem_mmio

Data-side memory subsystem for the pipelined MIPS core. It attaches directly to the core's memory-stage data port (`dmem_write`, `alu_out`, `dmem_write_data`, `dmem_read_data`). It provides word-addressed data RAM, a free-running 32-bit cycle counter, and a memory-mapped transmit FIFO that drains to an external sink over a valid/ready handshake. Reads are combinational so the core's M-stage timing is preserved; all state updates occur on the rising clock edge.

## Interface
- `RAM_WORDS`, 256: data RAM depth in 32-bit words; must be a power of two, ≤ 2^29.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two, 2–128.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dmem_write`  in  1  write strobe from the core's M stage.
- `alu_out`  in  32  byte address from the core; bits [1:0] are ignored.
- `dmem_write_data`  in  32  store data.
- `dmem_read_data`  out  32  load data; combinational function of `alu_out` and current state.
- `out_valid`  out  1  TX FIFO non-empty.
- `out_data`  out  32  TX FIFO head entry.
- `out_ready`  in  1  sink accepts head this cycle.

## Operation
- Address decode, using word address `a = alu_out[31:2]`:
  - `alu_out[31]==0`: RAM, index `a mod RAM_WORDS`. Upper address bits alias.
  - `0xFFFF0000` CYCLE: read returns the counter; write loads `dmem_write_data`.
  - `0xFFFF0004` STATUS: read returns `{21'b0, overflow, empty, full, count[7:0]}` (bit 10 overflow, bit 9 empty, bit 8 full). Any write clears `overflow`.
  - `0xFFFF0008` TX: write pushes `dmem_write_data`; read returns 0.
  - Any other address with bit 31 set: read returns 0; write is ignored.
- No read side effects. Reads never alter state.
- RAM: write when `dmem_write` and the address is in RAM space. Contents are not cleared by reset.
- Counter: increments by 1 each cycle and wraps from 0xFFFFFFFF to 0. A write to CYCLE takes priority over the increment in the same cycle.
- FIFO is a circular buffer with a head pointer, a tail pointer, and a count (0..FIFO_DEPTH).
  - `pop = out_valid & out_ready`.
  - `push_req = dmem_write & (addr == TX)`.
  - A push is accepted iff `push_req & (!full | pop)`.
  - Full with pop and push in the same cycle: both occur and count is unchanged.
  - Empty: no pop can occur, so a push is accepted.
  - A rejected push sets sticky `overflow` and leaves the data unchanged.
  - Clear priority: if a STATUS write and a rejected push fall in the same cycle, `overflow` ends at 1.
- Pointers wrap modulo FIFO_DEPTH.
- `out_valid = (count != 0)`. `out_data = mem[head]`, which is stable while `out_valid & !out_ready`.

## Timing
- Reset values, applied asynchronously while `reset == 0`:
  - counter = 0, count = 0, head = tail = 0, overflow = 0, FIFO storage = 0.
  - Therefore `out_valid = 0` and `out_data = 0`.
  - `dmem_read_data` follows decode: RAM reads are unaffected by reset; CYCLE/STATUS reads reflect the reset values.
- Reset asserted mid-operation: the FIFO is flushed immediately and queued entries are lost. RAM is retained.
- Read latency is 0 cycles (combinational).
- Write-to-read: a value written at edge N is visible to a read in cycle N+1. Same-cycle read of the address being written returns the old value.
- Push-to-`out_valid`: a push accepted at edge N with the FIFO previously empty raises `out_valid` in cycle N+1.
- Pop: head advances at the edge where `pop` is high. The next entry, if any, appears in the following cycle.
- Counter read at cycle N after release of reset at edge 0 returns N.

## Test plan
- Reset, write RAM[0x10] = 0xDEADBEEF, read 0x10 → 0xDEADBEEF. Read 0x410 with RAM_WORDS=256 → 0xDEADBEEF (alias). Read 0xFFFF000C → 0.
- Release reset, hold 5 cycles, read CYCLE → 5. Write CYCLE = 0xFFFFFFFE, then read over the next cycles → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- `out_ready = 0`, push 1, 2, 3, 4 → STATUS = 0x104. Push 5 → STATUS = 0x504. Write STATUS → 0x104. Set `out_ready = 1` → `out_data` shows 1, 2, 3, 4 on consecutive cycles, then `out_valid = 0` and STATUS = 0x200.
- FIFO full with `out_ready = 1` and push 9 in the same cycle → overflow stays 0, count stays 4, and 9 emerges last.
- Push 0xA5 then assert `reset` low mid-drain → `out_valid` drops without waiting for a clock edge. STATUS = 0x200 after release. Previously written RAM word is unchanged.

Source files
------------

// File: rtl/mips_dmem_mmio.sv
// mips_dmem_mmio
// Data-side memory subsystem for the pipelined MIPS core's memory stage.
// It provides a word-addressed data RAM, a free-running 32-bit cycle counter,
// and a memory-mapped transmit FIFO that drains to an external sink over a
// valid/ready handshake. Reads are purely combinational so the core's M-stage
// timing is preserved; all state changes happen on the rising clock edge,
// except the asynchronous reset.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-low reset
//   dmem_write       store strobe from the core
//   alu_out          byte address from the core (bits [1:0] ignored)
//   dmem_write_data  store data
//   dmem_read_data   load data (combinational)
//   out_valid        TX FIFO holds at least one entry
//   out_data         TX FIFO head entry
//   out_ready        sink accepts the head entry this cycle
//
// Memory map (byte addresses):
//   0x00000000-0x7FFFFFFF  RAM, word index aliased modulo RAM_WORDS
//   0xFFFF0000             CYCLE  read counter / write loads counter
//   0xFFFF0004             STATUS {21'b0, overflow, empty, full, count[7:0]}
//   0xFFFF0008             TX     write pushes, read returns 0
//   other bit-31 addresses read 0, writes ignored

module mips_dmem_mmio #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] alu_out,
    input  logic [31:0] dmem_write_data,
    output logic [31:0] dmem_read_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Word addresses (byte address >> 2) of the memory-mapped registers.
    localparam logic [29:0] CYCLE_WORD  = 30'h3FFF_C000;
    localparam logic [29:0] STATUS_WORD = 30'h3FFF_C001;
    localparam logic [29:0] TX_WORD     = 30'h3FFF_C002;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]       w_word;
    logic              w_isRam;
    logic              w_isCycle;
    logic              w_isStatus;
    logic              w_isTx;
    logic [RAM_AW-1:0] w_ramIdx;
    logic              w_unusedByteOffset;

    assign w_word             = alu_out[31:2];
    assign w_isRam            = ~alu_out[31];
    assign w_isCycle          = (w_word == CYCLE_WORD);
    assign w_isStatus         = (w_word == STATUS_WORD);
    assign w_isTx             = (w_word == TX_WORD);
    // Upper RAM-space address bits are simply dropped, so they alias.
    assign w_ramIdx           = alu_out[RAM_AW+1:2];
    assign w_unusedByteOffset = ^alu_out[1:0];

    // ------------------------------------------------------------------
    // Data RAM: deliberately has no reset so its contents survive one.
    // ------------------------------------------------------------------
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (dmem_write && w_isRam) begin
            r_ram[w_ramIdx] <= dmem_write_data;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter: a software load wins over the increment.
    // ------------------------------------------------------------------
    logic [31:0] r_cycle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else if (dmem_write && w_isCycle) begin
            r_cycle <= dmem_write_data;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO control
    // ------------------------------------------------------------------
    logic [31:0]      r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_pushReq;
    logic             w_pushOk;
    logic [7:0]       w_count8;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign out_valid = ~w_empty;
    assign out_data  = r_fifoMem[r_head];
    assign w_pop     = out_valid & out_ready;
    assign w_pushReq = dmem_write & w_isTx;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_pushOk  = w_pushReq & (~w_full | w_pop);
    assign w_count8  = 8'(r_count);

    // Storage is reset too, so out_data reads 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifoMem[i] <= '0;
            end
        end else if (w_pushOk) begin
            r_fifoMem[r_tail] <= dmem_write_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a rejected push beats a same-cycle STATUS clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_pushReq && !w_pushOk) begin
            r_overflow <= 1'b1;
        end else if (dmem_write && w_isStatus) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux; reads never change state.
    // ------------------------------------------------------------------
    always_comb begin
        dmem_read_data = '0;
        if (w_isRam) begin
            dmem_read_data = r_ram[w_ramIdx];
        end else if (w_isCycle) begin
            dmem_read_data = r_cycle;
        end else if (w_isStatus) begin
            dmem_read_data = {21'b0, r_overflow, w_empty, w_full, w_count8};
        end
    end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// tb_mips_dmem_mmio
// Self-checking bench for mips_dmem_mmio: reset checks, a table of directed
// vectors with hand-derived expectations, an asynchronous mid-drain reset
// sequence, and a randomized phase compared against a queue-based model.

module tb_mips_dmem_mmio;

    localparam logic [31:0] CY_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] ST_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] TX_ADDR = 32'hFFFF_0008;
    localparam int          DEPTH   = 4;
    localparam int          WORDS   = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dmem_write = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] dmem_write_data = '0;
    logic        out_ready = 1'b0;
    logic [31:0] dmem_read_data;
    logic        out_valid;
    logic [31:0] out_data;

    int testCount = 0;
    int failCount = 0;

    mips_dmem_mmio #(.RAM_WORDS(WORDS), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_write      (dmem_write),
        .alu_out         (alu_out),
        .dmem_write_data (dmem_write_data),
        .dmem_read_data  (dmem_read_data),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: plain arrays, a queue and an integer counter.
    // ------------------------------------------------------------------
    logic [31:0] mRam [WORDS];
    bit          mKnown [WORDS];
    logic [31:0] mQ [$];
    logic [31:0] mCycle;
    bit          mOvf;

    function automatic int ramIndex(input logic [31:0] addr);
        return int'((addr >> 2) % WORDS);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        logic [31:0] a;
        int          n;
        a = {addr[31:2], 2'b00};
        n = mQ.size();
        if (!a[31]) return mRam[ramIndex(a)];
        if (a == CY_ADDR) return mCycle;
        if (a == ST_ADDR) return 32'(mOvf) * 1024 + 32'(n == 0) * 512
                                 + 32'(n == DEPTH) * 256 + 32'(n);
        return 32'd0;
    endfunction

    function automatic bit readKnown(input logic [31:0] addr);
        if (addr[31]) return 1'b1;
        return mKnown[ramIndex(addr)];
    endfunction

    task automatic modelReset();
        mQ.delete();
        mCycle = '0;
        mOvf   = 1'b0;
    endtask

    task automatic modelUpdate();
        logic [31:0] a;
        bit          pop;
        bit          pushReq;
        bit          accept;
        a       = {alu_out[31:2], 2'b00};
        pop     = (mQ.size() != 0) && out_ready;
        pushReq = dmem_write && (a == TX_ADDR);
        accept  = pushReq && ((mQ.size() < DEPTH) || pop);
        if (dmem_write && !a[31]) begin
            mRam[ramIndex(a)]   = dmem_write_data;
            mKnown[ramIndex(a)] = 1'b1;
        end
        if (dmem_write && a == CY_ADDR) mCycle = dmem_write_data;
        else                            mCycle = mCycle + 32'd1;
        if (pushReq && !accept)              mOvf = 1'b1;
        else if (dmem_write && a == ST_ADDR) mOvf = 1'b0;
        if (pop)    void'(mQ.pop_front());
        if (accept) mQ.push_back(dmem_write_data);
    endtask

    // ------------------------------------------------------------------
    // Stimulus and checking helpers
    // ------------------------------------------------------------------
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic rdy);
        dmem_write      = we;
        alu_out         = addr;
        dmem_write_data = wd;
        out_ready       = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkModel();
        if (readKnown(alu_out)) checkOutput("rand_read", dmem_read_data, modelRead(alu_out));
        checkOutput("rand_valid", {31'b0, out_valid}, {31'b0, mQ.size() != 0});
        if (mQ.size() != 0) checkOutput("rand_data", out_data, mQ[0]);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        bit          chkRead;
        logic [31:0] expRead;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [$];

    task automatic addVec(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic rdy, input bit chk, input logic [31:0] er,
                          input logic ev, input logic [31:0] ed);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.rdy = rdy;
        v.chkRead = chk; v.expRead = er; v.expValid = ev; v.expData = ed;
        vecs.push_back(v);
    endtask

    initial begin
        // RAM write, read-back, alias and unmapped read
        addVec(1, 32'h10,  32'hDEADBEEF, 0, 0, 0,            0, 0);
        addVec(0, 32'h10,  0,            0, 1, 32'hDEADBEEF, 0, 0);
        addVec(0, 32'h410, 0,            0, 1, 32'hDEADBEEF, 0, 0);
        addVec(0, 32'hFFFF000C, 0,       0, 1, 0,            0, 0);
        addVec(0, ST_ADDR, 0,            0, 1, 32'h200,      0, 0);
        // Fill, overflow, clear, drain
        addVec(1, TX_ADDR, 1, 0, 1, 0,        0, 0);
        addVec(1, TX_ADDR, 2, 0, 1, 0,        1, 1);
        addVec(1, TX_ADDR, 3, 0, 1, 0,        1, 1);
        addVec(1, TX_ADDR, 4, 0, 1, 0,        1, 1);
        addVec(0, ST_ADDR, 0, 0, 1, 32'h104,  1, 1);
        addVec(1, TX_ADDR, 5, 0, 1, 0,        1, 1);
        addVec(0, ST_ADDR, 0, 0, 1, 32'h504,  1, 1);
        addVec(1, ST_ADDR, 0, 0, 1, 32'h504,  1, 1);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h104,  1, 1);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h003,  1, 2);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h002,  1, 3);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h001,  1, 4);
        addVec(0, ST_ADDR, 0, 0, 1, 32'h200,  0, 0);
        // Full FIFO with simultaneous pop and push
        addVec(1, TX_ADDR, 5, 0, 1, 0,        0, 0);
        addVec(1, TX_ADDR, 6, 0, 1, 0,        1, 5);
        addVec(1, TX_ADDR, 7, 0, 1, 0,        1, 5);
        addVec(1, TX_ADDR, 8, 0, 1, 0,        1, 5);
        addVec(1, TX_ADDR, 9, 1, 1, 0,        1, 5);
        addVec(0, ST_ADDR, 0, 0, 1, 32'h104,  1, 6);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h104,  1, 6);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h003,  1, 7);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h002,  1, 8);
        addVec(0, ST_ADDR, 0, 1, 1, 32'h001,  1, 9);
        addVec(0, ST_ADDR, 0, 0, 1, 32'h200,  0, 0);
        // Counter load and wrap
        addVec(1, CY_ADDR, 32'hFFFFFFFE, 0, 0, 0,            0, 0);
        addVec(0, CY_ADDR, 0,            0, 1, 32'hFFFFFFFE, 0, 0);
        addVec(0, CY_ADDR, 0,            0, 1, 32'hFFFFFFFF, 0, 0);
        addVec(0, CY_ADDR, 0,            0, 1, 32'h00000000, 0, 0);
    end

    // ------------------------------------------------------------------
    // Main test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rnd;
        logic [31:0] addr;
        int          sel;

        modelReset();

        // Reset state
        @(negedge clk);
        applyStimulus(0, CY_ADDR, 0, 0);
        checkOutput("reset_cycle", dmem_read_data, 0);
        checkOutput("reset_valid", {31'b0, out_valid}, 0);
        checkOutput("reset_data", out_data, 0);
        applyStimulus(0, ST_ADDR, 0, 0);
        checkOutput("reset_status", dmem_read_data, 32'h200);
        @(negedge clk);
        applyStimulus(0, CY_ADDR, 0, 0);
        checkOutput("reset_cycle_held", dmem_read_data, 0);

        // Release reset and count cycles
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, CY_ADDR, 0, 0);
            checkOutput("cycle_count", dmem_read_data, 32'(i));
            tick();
        end
        applyStimulus(0, CY_ADDR, 0, 0);
        checkOutput("cycle_after_5", dmem_read_data, 32'd5);

        // Directed table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
            if (vecs[i].chkRead) checkOutput($sformatf("vec%0d_read", i), dmem_read_data, vecs[i].expRead);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].expValid});
            if (vecs[i].expValid) checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].expData);
            tick();
        end

        // Asynchronous reset in the middle of a drain
        applyStimulus(1, TX_ADDR, 32'hA5, 0);
        checkOutput("mid_valid_pre", {31'b0, out_valid}, 0);
        tick();
        applyStimulus(1, TX_ADDR, 32'hB6, 1);
        checkOutput("mid_head_a5", out_data, 32'hA5);
        tick();
        applyStimulus(0, CY_ADDR, 0, 1);
        checkOutput("mid_valid_b6", {31'b0, out_valid}, 1);
        checkOutput("mid_head_b6", out_data, 32'hB6);
        #1 reset = 1'b0;
        #1;
        checkOutput("async_valid_drop", {31'b0, out_valid}, 0);
        checkOutput("async_data_clear", out_data, 0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, ST_ADDR, 0, 0);
        checkOutput("post_reset_status", dmem_read_data, 32'h200);
        applyStimulus(0, 32'h10, 0, 0);
        checkOutput("ram_retained", dmem_read_data, 32'hDEADBEEF);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rnd = $urandom();
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: addr = rnd & 32'h7FFF_F03F;
                4:          addr = CY_ADDR | (rnd & 32'h3);
                5:          addr = ST_ADDR | (rnd & 32'h3);
                6, 7:       addr = TX_ADDR | (rnd & 32'h3);
                default:    addr = 32'h8000_0000 | rnd;
            endcase
            applyStimulus(($urandom_range(0, 2) != 0), addr, $urandom(),
                          ($urandom_range(0, 2) == 0));
            checkModel();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
